// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep sequencer.
// Optional build macro TT_SWEEP_SYNC_EN (see tt_sweep_ctrl) uses SYNC_STAGES.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } tt_sweep_state_e;

  localparam int NUM_ROWS    = 8;
  localparam int ROW_W       = 3;
  localparam int SIG_W       = 8;
  localparam int SYNC_STAGES = 2;

  // Row 000 lands in the MSB so a gate named 0xHH produces signature 8'hHH.
  function automatic logic [ROW_W-1:0] row_to_bit(input logic [ROW_W-1:0] row);
    return ROW_W'(NUM_ROWS - 1) - row;
  endfunction

endpackage

// File: rtl/tt_sweep_sync.sv
// Multi-flop synchroniser for the gate output; built only with TT_SWEEP_SYNC_EN.
module tt_sweep_sync
  import tt_sweep_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps a 3-input gate through rows 000..111, captures its truth-table code and
// compares it with a latched expected code. Macro TT_SWEEP_SYNC_EN adds an input synchroniser.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SIG_W-1:0]      expected,
  output logic [ROW_W-1:0]      dut_in,
  input  logic                  dut_out,
  output logic                  busy,
  output logic                  done,
  output logic [SIG_W-1:0]      signature,
  output logic                  match,
  output tt_sweep_state_e       dbg_state
);

`ifdef TT_SWEEP_SYNC_EN
  // Two extra settle cycles cover the synchroniser latency.
  localparam int RELOAD = SETTLE_CYCLES + 1;
`else
  localparam int RELOAD = SETTLE_CYCLES - 1;
`endif
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(RELOAD);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("tt_sweep_ctrl: SETTLE_CYCLES must be in 1..255");
  end
  if (CNT_W < $clog2(SETTLE_CYCLES + 3)) begin : g_bad_cnt_w
    $error("tt_sweep_ctrl: CNT_W too narrow for SETTLE_CYCLES+2");
  end

  logic sample_bit;

`ifdef TT_SWEEP_SYNC_EN
  tt_sweep_sync u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (dut_out),
    .q_o    (sample_bit)
  );
`else
  assign sample_bit = dut_out;
`endif

  tt_sweep_state_e  state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] exp_q, exp_d;
  logic             match_q, match_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      sig_q   <= '0;
      exp_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      exp_q   <= exp_d;
      match_q <= match_d;
    end
  end

  // start is a level request accepted only in IDLE (no queuing); done pulses for the single DONE cycle.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    exp_d   = exp_q;
    match_d = match_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = expected;
          row_d   = '0;
          cnt_d   = CNT_RELOAD;
          sig_d   = '0;
          match_d = 1'b0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SAMPLE: begin
        sig_d[row_to_bit(row_q)] = sample_bit;
        if (row_q == ROW_W'(NUM_ROWS - 1)) begin
          match_d = (sig_d == exp_q);
          state_d = DONE;
        end else begin
          row_d   = row_q + 1'b1;
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dut_in    = row_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign signature = sig_q;
  assign match     = match_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: three instances (default settle, and two SETTLE_CYCLES=1 units
// driving delayed gate models); works with or without TT_SWEEP_SYNC_EN.
module tb_tt_sweep_ctrl;
  import tt_sweep_pkg::*;

`ifdef TT_SWEEP_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int S_A   = 4;
  localparam int S_B   = 1;
  localparam int LEN_A = S_A + 1 + EXTRA;
  localparam int LEN_B = S_B + 1 + EXTRA;
  localparam int W     = 25;  // {done_cycle[15:0], match, signature[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: default settle, combinational gate 0x37 ----------------
  logic       start_a = 1'b0;
  logic [7:0] exp_a = 8'h00;
  logic [2:0] din_a;
  logic       dout_a, busy_a, done_a, match_a;
  logic [7:0] sig_a;
  tt_sweep_state_e st_a;
  logic [7:0] gate_37 = 8'h37;
  assign dout_a = gate_37[~din_a];

  tt_sweep_ctrl #(.SETTLE_CYCLES(S_A), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a),
    .dut_in(din_a), .dut_out(dout_a), .busy(busy_a), .done(done_a),
    .signature(sig_a), .match(match_a), .dbg_state(st_a)
  );

  // ---------------- DUT B: settle 1, gate 0xE1 with 1-cycle output delay ----------------
  logic       start_b = 1'b0;
  logic [7:0] exp_b = 8'h00;
  logic [2:0] din_b;
  logic       dout_b, busy_b, done_b, match_b;
  logic [7:0] sig_b;
  tt_sweep_state_e st_b;
  logic [7:0] gate_e1 = 8'hE1;
  logic       db1 = 1'b0;
  always @(posedge clk) db1 <= gate_e1[~din_b];
  assign dout_b = db1;

  tt_sweep_ctrl #(.SETTLE_CYCLES(S_B), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b),
    .dut_in(din_b), .dut_out(dout_b), .busy(busy_b), .done(done_b),
    .signature(sig_b), .match(match_b), .dbg_state(st_b)
  );

  // ---------------- DUT C: settle 1, gate 0xE1 with 2-cycle output delay ----------------
  logic       start_c = 1'b0;
  logic [7:0] exp_c = 8'h00;
  logic [2:0] din_c;
  logic       dout_c, busy_c, done_c, match_c;
  logic [7:0] sig_c;
  tt_sweep_state_e st_c;
  logic       dc1 = 1'b0, dc2 = 1'b0;
  always @(posedge clk) begin
    dc1 <= gate_e1[~din_c];
    dc2 <= dc1;
  end
  assign dout_c = dc2;

  tt_sweep_ctrl #(.SETTLE_CYCLES(S_B), .CNT_W(8)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .expected(exp_c),
    .dut_in(din_c), .dut_out(dout_c), .busy(busy_c), .done(done_c),
    .signature(sig_c), .match(match_c), .dbg_state(st_c)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];
  logic [W-1:0] exp_qc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  logic [W-1:0] ea, eb, ec;
  always @(negedge clk) begin
    if (rst_n && done_a === 1'b1) begin
      if (exp_qa.size() == 0) chk("a_spurious_done", 32'd1, 32'd0);
      else begin
        ea = exp_qa.pop_front();
        chk("a_done_cycle", cyc, 32'(ea[24:9]));
        chk("a_signature", 32'(sig_a), 32'(ea[7:0]));
        chk("a_match", 32'(match_a), 32'(ea[8]));
        chk("a_busy_in_done", 32'(busy_a), 32'd1);
      end
    end
    if (rst_n && done_b === 1'b1) begin
      if (exp_qb.size() == 0) chk("b_spurious_done", 32'd1, 32'd0);
      else begin
        eb = exp_qb.pop_front();
        chk("b_done_cycle", cyc, 32'(eb[24:9]));
        chk("b_signature", 32'(sig_b), 32'(eb[7:0]));
        chk("b_match", 32'(match_b), 32'(eb[8]));
      end
    end
    if (rst_n && done_c === 1'b1) begin
      if (exp_qc.size() == 0) chk("c_spurious_done", 32'd1, 32'd0);
      else begin
        ec = exp_qc.pop_front();
        chk("c_done_cycle", cyc, 32'(ec[24:9]));
        chk("c_signature", 32'(sig_c), 32'(ec[7:0]));
        chk("c_match", 32'(match_c), 32'(ec[8]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input int d, input logic [7:0] e, input logic [7:0] sig,
                        input logic m, input bit push, output int unsigned e0);
    @(negedge clk);
    e0 = cyc + 1;
    case (d)
      0: begin
        exp_a = e; start_a = 1'b1;
        if (push) exp_qa.push_back({16'(e0 + 8 * LEN_A), m, sig});
      end
      1: begin
        exp_b = e; start_b = 1'b1;
        if (push) exp_qb.push_back({16'(e0 + 8 * LEN_B), m, sig});
      end
      default: begin
        exp_c = e; start_c = 1'b1;
        if (push) exp_qc.push_back({16'(e0 + 8 * LEN_B), m, sig});
      end
    endcase
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  // Called at the negedge where cyc == E0; checks dut_in at each row's first and last cycle
  // and optionally pulses start at offsets inj1/inj2 from E0.
  task automatic track_rows_a(input int inj1, input int inj2);
    for (int k = 0; k < 8 * LEN_A; k++) begin
      if (k % LEN_A == 0 || k % LEN_A == LEN_A - 1)
        chk("a_dut_in_row", 32'(din_a), 32'(k / LEN_A));
      start_a = (k == inj1 - 1 || k == inj2 - 1);
      @(negedge clk);
    end
    start_a = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget);
    logic b;
    for (int i = 0; i < budget; i++) begin
      b = (d == 0) ? busy_a : (d == 1) ? busy_b : busy_c;
      if (b === 1'b0) return;
      @(negedge clk);
    end
    chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned e0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dut_in", 32'(din_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_signature", 32'(sig_a), 32'h00);
    chk("rst_match", 32'(match_a), 32'd0);
    chk("rst_state", 32'(st_a), 32'(IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Gate 0x37, expected 0x37
    launch(0, 8'h37, 8'h37, 1'b1, 1'b1, e0);
    chk("t1_busy_start", 32'(busy_a), 32'd1);
    track_rows_a(-1, -1);
    @(negedge clk);
    chk("t1_busy_after_done", 32'(busy_a), 32'd0);
    repeat (4) @(negedge clk);
    chk("t1_match_held", 32'(match_a), 32'd1);
    chk("t1_sig_held", 32'(sig_a), 32'h37);

    // Expected 0x38 -> mismatch; changing expected mid-sweep must not matter
    launch(0, 8'h38, 8'h37, 1'b0, 1'b1, e0);
    repeat (10) @(negedge clk);
    exp_a = 8'h37;
    wait_idle(0, 100);
    repeat (3) @(negedge clk);
    chk("t2_match_held", 32'(match_a), 32'd0);
    chk("t2_sig_held", 32'(sig_a), 32'h37);

    // Reset while row 4 is driven
    launch(0, 8'h37, 8'h37, 1'b1, 1'b0, e0);
    repeat (4 * LEN_A + 1) @(negedge clk);
    chk("t3_row4", 32'(din_a), 32'd4);
    chk("t3_partial_sig", 32'(sig_a), 32'h30);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t3_dut_in", 32'(din_a), 32'd0);
    chk("t3_busy", 32'(busy_a), 32'd0);
    chk("t3_signature", 32'(sig_a), 32'h00);
    chk("t3_match", 32'(match_a), 32'd0);
    launch(0, 8'h37, 8'h37, 1'b1, 1'b1, e0);
    wait_idle(0, 100);

    // start pulses during a sweep are ignored
    launch(0, 8'h37, 8'h37, 1'b1, 1'b1, e0);
    track_rows_a(10, 8 * LEN_A);
    repeat (6) @(negedge clk);
    chk("t4_idle_after", 32'(busy_a), 32'd0);

    // start held high: second sweep one IDLE cycle after done
    @(negedge clk);
    e0 = cyc + 1;
    exp_a = 8'h37;
    start_a = 1'b1;
    exp_qa.push_back({16'(e0 + 8 * LEN_A), 1'b1, 8'h37});
    exp_qa.push_back({16'(e0 + 8 * LEN_A + 2 + 8 * LEN_A), 1'b1, 8'h37});
    for (int i = 0; i < 8 * LEN_A + 3; i++) begin
      @(negedge clk);
      if (cyc == e0 + 8 * LEN_A + 1) begin
        chk("t5_gap_busy", 32'(busy_a), 32'd0);
        chk("t5_gap_state", 32'(st_a), 32'(IDLE));
      end
      if (cyc == e0 + 8 * LEN_A + 2) begin
        chk("t5_second_accept", 32'(busy_a), 32'd1);
        start_a = 1'b0;
      end
    end
    start_a = 1'b0;
    wait_idle(0, 200);

    // Settle 1 with a 1-cycle-delay gate model
    launch(1, 8'hE1, 8'hE1, 1'b1, 1'b1, e0);
    wait_idle(1, 100);

    // Settle 1 with a 2-cycle-delay model: each row captures the previous row's output
    launch(2, 8'hE1, 8'hF0, 1'b0, 1'b1, e0);
    wait_idle(2, 100);

    repeat (5) @(negedge clk);
    chk("a_queue_drained", 32'(exp_qa.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_qb.size()), 32'd0);
    chk("c_queue_drained", 32'(exp_qc.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_sweep_ctrl.md
Name: tt_sweep_ctrl

Overview:
- Sequencer that characterises one 3-input truth-table gate (in1, in2, in3 → out).
- Drives all 8 input rows in order 000→111 and waits a programmable settle time per row.
- Samples the gate output into an 8-bit signature in hex-code order and compares it against an expected code.
- Sits beside a gate instance in self-test and characterisation wrappers; the gate is the datapath it sequences.

Parameters:
- SETTLE_CYCLES, 4, cycles dut_in is held before the sample cycle of each row. Legal range 1..255; 0 is an elaboration error.
- CNT_W, 8, width of the settle counter. Must hold SETTLE_CYCLES+2.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a sweep; honoured only in IDLE.
- expected  input  8  expected truth-table code; latched on the accepted start.
- dut_in  output  3  gate inputs; bit2=in1, bit1=in2, bit0=in3.
- dut_out  input  1  gate output.
- busy  output  1  high from the accepted start through the DONE cycle.
- done  output  1  single-cycle pulse when the sweep completes.
- signature  output  8  captured code; bit (7-row) = dut_out for row.
- match  output  1  signature == latched expected; valid from done, held until the next start.

Behaviour:
- Reset (rst_n=0 at an edge), effective next cycle from any state including mid-sweep:
  - state=IDLE, dut_in=000, busy=0, done=0, signature=8'h00, match=0.
  - latched expected=0, row=0, cnt=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start=1: latch expected, row←0, dut_in←000, cnt←SETTLE_CYCLES-1, signature←0, match←0, busy←1, go to SETTLE.
- SETTLE:
  - cnt==0 → go to SAMPLE; otherwise cnt←cnt-1.
- SAMPLE:
  - signature[7-row]←dut_out.
  - row==7 → go to DONE.
  - Otherwise row←row+1, dut_in←row+1, cnt←SETTLE_CYCLES-1, go to SETTLE.
- DONE:
  - done=1 and busy=1 for this one cycle.
  - match reflects the complete signature in this cycle.
  - Next state IDLE; busy←0.
- Timing:
  - Each row lasts exactly SETTLE_CYCLES+1 cycles.
  - dut_in changes only on row boundaries.
  - For a start accepted at edge E0, done is high in the cycle after edge E0+8·(SETTLE_CYCLES+1). Default: E0+40.
- start while busy (SETTLE, SAMPLE or DONE): ignored, no queuing.
- start held high continuously: a new sweep begins on the first IDLE cycle after DONE. Back-to-back sweeps are separated by exactly 1 IDLE cycle.
- signature and match hold their values in IDLE until the next accepted start clears them.
- expected changing mid-sweep has no effect.
- Row-to-bit mapping: row r = {in1,in2,in3}; signature bit 7 = row 000, bit 0 = row 111. A gate named 0xHH yields signature 8'hHH.

Optional Feature:
- Macro TT_SWEEP_SYNC_EN.
- Defined:
  - dut_out passes through a 2-flop synchroniser (reset value 0) before sampling.
  - cnt reload becomes SETTLE_CYCLES+1, so each row lasts SETTLE_CYCLES+3 cycles.
  - done occurs at E0+8·(SETTLE_CYCLES+3) (default E0+56).
- Undefined:
  - dut_out is sampled directly, with the timing given above.
- Port list is identical in both builds.

Decomposition:
- Package tt_sweep_pkg:
  - state enum tt_sweep_state_e {IDLE, SETTLE, SAMPLE, DONE}.
  - localparams NUM_ROWS=8, ROW_W=3, SIG_W=8, SYNC_STAGES=2.
  - function row_to_bit(row) returning 7-row.
- Sub-module tt_sweep_sync (2-flop synchroniser, synchronous active-low reset), instantiated only under TT_SWEEP_SYNC_EN.
- FSM, counter and capture stay in tt_sweep_ctrl.

Test Plan:
- Combinational gate model 0x37 on dut_in/dut_out, expected=8'h37, start pulse at E0 → dut_in steps 0..7 every 5 cycles; done at E0+40; signature=8'h37; match=1; busy low at E0+41.
- Same gate, expected=8'h38 → signature=8'h37, match=0, done at the same cycle.
- rst_n=0 for one edge while row=4 → next cycle dut_in=000, busy=0, signature=00. A fresh start then completes normally with signature 8'h37.
- start pulsed at E0+10 and E0+40 during a sweep → ignored; exactly one done; dut_in sequence unperturbed. start held high → second sweep accepted one IDLE cycle after done.
- SETTLE_CYCLES=1, gate model with 1-cycle output delay, expected=8'hE1 → signature 8'hE1, match=1, done at E0+16.
- Build with TT_SWEEP_SYNC_EN, gate 0x37 → done at E0+56, signature=8'h37. Without the sync stage and with SETTLE_CYCLES=1 plus a 2-cycle-delay model, the bench flags a mismatch.
